// File: rtl/p405s_lrctr_update.sv
// LR/CTR update unit: a one-entry execute-stage register that tracks pending
// link-register and count-register writes and commits them when execute advances.
module p405s_lrctr_update (
    input  logic        CB,
    input  logic        resetCore_L,
    input  logic        dcdValid,
    input  logic        dcdLrUpdate,
    input  logic        dcdLrSrcGpr,
    input  logic        dcdMtCtr,
    input  logic        dcdCtrUpForBcctr,
    input  logic        exeHold,
    input  logic        exeFlush,
    input  logic [0:31] exeGprData,
    input  logic [0:29] exeLinkAddr,
    output logic [0:31] lrQ,
    output logic [0:31] ctrQ,
    output logic        exeCtrZero,
    output logic        lrCtrBusy
);

    logic        exeValidReg,    exeValidNext;
    logic        exeLrWrReg,     exeLrWrNext;
    logic        exeLrSrcGprReg, exeLrSrcGprNext;
    logic        exeCtrMtReg,    exeCtrMtNext;
    logic        exeCtrDecReg,   exeCtrDecNext;
    logic [0:31] lrReg,  lrNext;
    logic [0:31] ctrReg, ctrNext;
    logic        exeCommit;

    // Flush beats both hold and a fresh load from decode.
    always_comb begin
        exeValidNext    = exeValidReg;
        exeLrWrNext     = exeLrWrReg;
        exeLrSrcGprNext = exeLrSrcGprReg;
        exeCtrMtNext    = exeCtrMtReg;
        exeCtrDecNext   = exeCtrDecReg;
        if (exeFlush) begin
            exeValidNext    = 1'b0;
            exeLrWrNext     = 1'b0;
            exeLrSrcGprNext = 1'b0;
            exeCtrMtNext    = 1'b0;
            exeCtrDecNext   = 1'b0;
        end else if (!exeHold) begin
            exeValidNext    = dcdValid;
            exeLrWrNext     = dcdValid & dcdLrUpdate;
            exeLrSrcGprNext = dcdValid & dcdLrSrcGpr;
            exeCtrMtNext    = dcdValid & dcdMtCtr;
            exeCtrDecNext   = dcdValid & dcdCtrUpForBcctr & ~dcdMtCtr;
        end
    end

    assign exeCommit = exeValidReg & ~exeHold & ~exeFlush;

    // LR and CTR commit independently; mtctr outranks a decrement.
    always_comb begin
        lrNext  = lrReg;
        ctrNext = ctrReg;
        if (exeCommit && exeLrWrReg) begin
            lrNext = exeLrSrcGprReg ? exeGprData : {exeLinkAddr, 2'b00};
        end
        if (exeCommit && exeCtrMtReg) begin
            ctrNext = exeGprData;
        end else if (exeCommit && exeCtrDecReg) begin
            ctrNext = ctrReg - 32'd1;
        end
    end

    always_ff @(posedge CB or negedge resetCore_L) begin
        if (!resetCore_L) begin
            exeValidReg    <= 1'b0;
            exeLrWrReg     <= 1'b0;
            exeLrSrcGprReg <= 1'b0;
            exeCtrMtReg    <= 1'b0;
            exeCtrDecReg   <= 1'b0;
            lrReg          <= 32'h0000_0000;
            ctrReg         <= 32'h0000_0000;
        end else begin
            exeValidReg    <= exeValidNext;
            exeLrWrReg     <= exeLrWrNext;
            exeLrSrcGprReg <= exeLrSrcGprNext;
            exeCtrMtReg    <= exeCtrMtNext;
            exeCtrDecReg   <= exeCtrDecNext;
            lrReg          <= lrNext;
            ctrReg         <= ctrNext;
        end
    end

    assign lrQ        = lrReg;
    assign ctrQ       = ctrReg;
    // Branch sees the post-decrement CTR: it reaches zero exactly when it is 1 now.
    assign exeCtrZero = exeValidReg & exeCtrDecReg & (ctrReg == 32'h0000_0001);
    assign lrCtrBusy  = exeValidReg & (exeLrWrReg | exeCtrMtReg | exeCtrDecReg);

endmodule

// File: tb/tb_p405s_lrctr_update.sv
// Directed bench for p405s_lrctr_update: stimulus queues expected per-cycle
// observations, a negedge monitor pops and compares them.
module tb_p405s_lrctr_update;

    logic        CB = 1'b0;
    logic        resetCore_L;
    logic        dcdValid, dcdLrUpdate, dcdLrSrcGpr, dcdMtCtr, dcdCtrUpForBcctr;
    logic        exeHold, exeFlush;
    logic [0:31] exeGprData;
    logic [0:29] exeLinkAddr;
    logic [0:31] lrQ, ctrQ;
    logic        exeCtrZero, lrCtrBusy;

    p405s_lrctr_update dut (
        .CB(CB), .resetCore_L(resetCore_L),
        .dcdValid(dcdValid), .dcdLrUpdate(dcdLrUpdate), .dcdLrSrcGpr(dcdLrSrcGpr),
        .dcdMtCtr(dcdMtCtr), .dcdCtrUpForBcctr(dcdCtrUpForBcctr),
        .exeHold(exeHold), .exeFlush(exeFlush),
        .exeGprData(exeGprData), .exeLinkAddr(exeLinkAddr),
        .lrQ(lrQ), .ctrQ(ctrQ), .exeCtrZero(exeCtrZero), .lrCtrBusy(lrCtrBusy)
    );

    always #5 CB = ~CB;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] lr;
        logic [31:0] ctr;
        logic        busy;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    always @(posedge CB) cyc++;

    always @(negedge CB) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || lrQ !== e.lr || ctrQ !== e.ctr ||
                lrCtrBusy !== e.busy || exeCtrZero !== e.zero) begin
                fails++;
                $display("FAIL %s cyc=%0d: got lr=%08h ctr=%08h busy=%b zero=%b, want lr=%08h ctr=%08h busy=%b zero=%b",
                         e.name, cyc, lrQ, ctrQ, lrCtrBusy, exeCtrZero, e.lr, e.ctr, e.busy, e.zero);
            end else begin
                $display("[%0d] %s ok lr=%08h ctr=%08h busy=%b zero=%b",
                         cyc, e.name, lrQ, ctrQ, lrCtrBusy, exeCtrZero);
            end
        end
    end

    task automatic tick();
        @(posedge CB);
        #1;
    endtask

    task automatic expectNow(input string name, input logic [31:0] lr, input logic [31:0] ctr,
                             input logic busy, input logic zero);
        sb.push_back('{cyc, name, lr, ctr, busy, zero});
    endtask

    task automatic setDcd(input logic v, input logic lu, input logic ls, input logic mt, input logic cu);
        dcdValid = v; dcdLrUpdate = lu; dcdLrSrcGpr = ls; dcdMtCtr = mt; dcdCtrUpForBcctr = cu;
    endtask

    task automatic doMtctr(input logic [31:0] val, input logic [31:0] lrNow,
                           input logic [31:0] ctrNow, input string tag);
        setDcd(1, 0, 0, 1, 1);
        exeGprData = 32'h0;
        tick();
        setDcd(0, 0, 0, 0, 0);
        exeGprData = val;
        expectNow({tag, "_exe"}, lrNow, ctrNow, 1'b1, 1'b0);
        tick();
        exeGprData = 32'h0;
        expectNow({tag, "_commit"}, lrNow, val, 1'b0, 1'b0);
    endtask

    task automatic doBc(input logic [31:0] ctrNow, input logic zero,
                        input logic [31:0] lrNow, input string tag);
        setDcd(1, 0, 0, 0, 1);
        tick();
        setDcd(0, 0, 0, 0, 0);
        expectNow({tag, "_exe"}, lrNow, ctrNow, 1'b1, zero);
        tick();
        expectNow({tag, "_commit"}, lrNow, ctrNow - 32'd1, 1'b0, 1'b0);
    endtask

    initial begin
        resetCore_L = 1'b0;
        setDcd(0, 0, 0, 0, 0);
        exeHold = 1'b0; exeFlush = 1'b0;
        exeGprData = 32'h0; exeLinkAddr = 30'h0;
        tick();
        expectNow("reset", 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        resetCore_L = 1'b1;

        // mtctr, then CTR=1 and two decrements across zero
        doMtctr(32'h1234_5678, 32'h0, 32'h0, "mtctr");
        doMtctr(32'h0000_0001, 32'h0, 32'h1234_5678, "mtctr1");
        doBc(32'h0000_0001, 1'b1, 32'h0, "bc1");
        doBc(32'h0000_0000, 1'b0, 32'h0, "bc0");

        // bl: link address word 0x401 -> LR 0x1004
        setDcd(1, 1, 0, 0, 0);
        tick();
        setDcd(0, 0, 0, 0, 0);
        exeLinkAddr = 30'h401;
        expectNow("bl_exe", 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        tick();
        expectNow("bl_commit", 32'h0000_1004, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // mtlr held three cycles, then flushed; a waiting mtctr must not load
        setDcd(1, 1, 1, 0, 0);
        tick();
        setDcd(1, 0, 0, 1, 1);
        exeGprData = 32'hDEAD_BEEF;
        exeHold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expectNow("hold", 32'h0000_1004, 32'hFFFF_FFFF, 1'b1, 1'b0);
            tick();
        end
        exeFlush = 1'b1;
        expectNow("flush_exe", 32'h0000_1004, 32'hFFFF_FFFF, 1'b1, 1'b0);
        tick();
        exeFlush = 1'b0; exeHold = 1'b0;
        setDcd(0, 1, 1, 1, 1);
        exeGprData = 32'h0BAD_F00D;
        expectNow("flush_after", 32'h0000_1004, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        setDcd(0, 0, 0, 0, 0);
        expectNow("bubble", 32'h0000_1004, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        exeGprData = 32'h0;
        expectNow("bubble2", 32'h0000_1004, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // combined link + decrement commits both on one edge
        doMtctr(32'h0000_0005, 32'h0000_1004, 32'hFFFF_FFFF, "mtctr5");
        setDcd(1, 1, 0, 0, 1);
        tick();
        setDcd(0, 0, 0, 0, 0);
        exeLinkAddr = 30'h12345;
        expectNow("comb_exe", 32'h0000_1004, 32'h5, 1'b1, 1'b0);
        tick();
        expectNow("comb_commit", 32'h0004_8D14, 32'h4, 1'b0, 1'b0);

        // back-to-back decrements
        setDcd(1, 0, 0, 0, 1);
        tick();
        expectNow("b2b_exe1", 32'h0004_8D14, 32'h4, 1'b1, 1'b0);
        tick();
        setDcd(0, 0, 0, 0, 0);
        expectNow("b2b_exe2", 32'h0004_8D14, 32'h3, 1'b1, 1'b0);
        tick();
        expectNow("b2b_commit", 32'h0004_8D14, 32'h2, 1'b0, 1'b0);

        // async reset while an mtctr is pending under hold
        doMtctr(32'h0000_000A, 32'h0004_8D14, 32'h2, "mtctrA");
        setDcd(1, 0, 0, 1, 1);
        tick();
        setDcd(0, 0, 0, 0, 0);
        exeHold = 1'b1;
        exeGprData = 32'h0000_0055;
        expectNow("rst_pend", 32'h0004_8D14, 32'hA, 1'b1, 1'b0);
        tick();
        #2;
        resetCore_L = 1'b0;
        expectNow("rst_async", 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        expectNow("rst_held", 32'h0, 32'h0, 1'b0, 1'b0);
        resetCore_L = 1'b1;
        exeHold = 1'b0;
        exeGprData = 32'h0;
        doMtctr(32'h0000_0077, 32'h0, 32'h0, "resume");

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
